// File: rtl/timer_pkg.sv
// Shared definitions for the timer arbiter: FSM state encoding and a one-hot helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_pkg;

    // Upper bound on requesters; onehot() returns this many bits and callers
    // cast the result down to their own requester count.
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
        onehot = MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/timer_arbiter_rr_pick.sv
// Round-robin priority picker: first asserted req at or above ptr, wrapping.
// Latency: combinational.
// Backpressure: none; valid simply mirrors |req.
// Ports: req (request vector), ptr (search start), valid (any request), index (winner).
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    always_comb begin
        int               j;
        logic [IDX_W-1:0] cand;
        j     = 0;
        cand  = '0;
        valid = |req;
        index = '0;
        // Walk offsets from farthest to nearest so the candidate closest to
        // ptr (in wrapped order) is the last one written and therefore wins.
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            j = int'(ptr) + off;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            cand = IDX_W'(j);
            if (req[cand]) begin
                index = cand;
            end
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// Shares one down-counting timer between NUM_REQ requesters, granted round-robin.
// Latency: grant one edge after request in IDLE; done D+1 edges after grant; next grant 2 edges after done.
// Backpressure: non-owners wait (req held) until the owner finishes or aborts.
// Ports: clk, reset (sync, active-high), req/req_delay (per-requester level and delay),
//        grant/done (one-hot owner / expiry pulse), busy (not idle), count (remaining ticks).
module timer_arbiter
    import timer_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_delay,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REQ-1:0]             done,
    output logic                           busy,
    output logic [DATA_WIDTH-1:0]          count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e                  state_q,  state_d;
    logic [IDX_W-1:0]        owner_q,  owner_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0]   count_q,  count_d;

    logic                    pick_vld;
    logic [IDX_W-1:0]        pick_idx;
    logic [IDX_W-1:0]        owner_inc;
    logic [NUM_REQ-1:0]      owner_oh;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .valid (pick_vld),
        .index (pick_idx)
    );

    // Owner + 1 modulo NUM_REQ (NUM_REQ need not be a power of two).
    assign owner_inc = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        count_d  = count_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    owner_d = pick_idx;
                    count_d = req_delay[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                // Abort is checked first so it beats expiry in the same cycle.
                if (!req[owner_q]) begin
                    count_d  = '0;
                    rr_ptr_d = owner_inc;
                    state_d  = S_IDLE;
                end else if (count_q != '0) begin
                    count_d = count_q - DATA_WIDTH'(1);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                rr_ptr_d = owner_inc;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Outputs decode straight from state so grant and done can never overlap.
    assign owner_oh = NUM_REQ'(onehot(32'(owner_q)));
    assign grant    = (state_q == S_COUNT) ? owner_oh : '0;
    assign done     = (state_q == S_DONE)  ? owner_oh : '0;
    assign busy     = (state_q != S_IDLE);
    assign count    = count_q;

endmodule
